// File: rtl/round_ctrl.sv
// round_ctrl: game round sequencer for a reaction game.
// Ports: clk, rst (sync, active-high); start, abort (levels); tick (timebase enable);
//   hit (player strike pulse); jump_start/new_ball (target pulses); ball_visible;
//   score/misses/round_num (8-bit tallies); react_time (16-bit ticks); busy; done.
module round_ctrl #(
  parameter int ROUNDS    = 10,
  parameter int TIMEOUT   = 1500,
  parameter int GAP_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        tick,
  input  logic        hit,
  output logic        jump_start,
  output logic        new_ball,
  output logic        ball_visible,
  output logic [7:0]  score,
  output logic [7:0]  misses,
  output logic [7:0]  round_num,
  output logic [15:0] react_time,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] G_LAST = 16'(GAP_TICKS - 1);
  localparam logic [7:0]  R_LAST = 8'(ROUNDS);
  state_t      state;
  logic [15:0] timer, gap_cnt;
  logic [7:0]  round_nxt;
  logic        last;
  assign round_nxt = round_num + 8'd1;
  assign last      = round_nxt == R_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      gap_cnt      <= '0;
      jump_start   <= 1'b0;
      new_ball     <= 1'b0;
      ball_visible <= 1'b0;
      score        <= '0;
      misses       <= '0;
      round_num    <= '0;
      react_time   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      jump_start <= 1'b0;
      new_ball   <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        ball_visible <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            state        <= ACTIVE;
            jump_start   <= 1'b1;
            ball_visible <= 1'b1;
            score        <= '0;
            misses       <= '0;
            round_num    <= '0;
            react_time   <= '0;
            timer        <= '0;
            gap_cnt      <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
          ACTIVE: begin
            // a hit on the timeout tick is resolved as a hit
            if (hit || (tick && timer == T_LAST)) begin
              score        <= hit ? score + 8'd1 : score;
              misses       <= hit ? misses : misses + 8'd1;
              react_time   <= hit ? timer : react_time;
              round_num    <= round_nxt;
              ball_visible <= 1'b0;
              gap_cnt      <= '0;
              state        <= last ? DONE : GAP;
              busy         <= !last;
              done         <= last;
            end else if (tick) begin
              timer <= timer + 16'd1;
            end
          end
          GAP: if (tick) begin
            if (gap_cnt == G_LAST) begin
              state        <= ACTIVE;
              new_ball     <= 1'b1;
              ball_visible <= 1'b1;
              timer        <= '0;
              gap_cnt      <= '0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 10: targets per game; legal range 1..255.
REQ-002 SHALL have parameter TIMEOUT, default 1500: ticks a target stays live before a miss; legal range 1..65535.
REQ-003 SHALL have parameter GAP_TICKS, default 500: ticks between targets; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; begins a game when sampled high in IDLE or DONE.
REQ-007 abort  input  1  level; ends the current game and returns to IDLE.
REQ-008 tick  input  1  one-cycle timebase enable (e.g. 1 ms); all timing counts ticks, not clocks.
REQ-009 hit  input  1  one-cycle pulse: player struck the current target.
REQ-010 jump_start  output  1  one-cycle pulse: first target of a game; drives the position generator.
REQ-011 new_ball  output  1  one-cycle pulse: each subsequent target; drives the position generator.
REQ-012 ball_visible  output  1  high while a target is live.
REQ-013 score  output  8  hits this game.
REQ-014 misses  output  8  timeouts this game.
REQ-015 round_num  output  8  targets resolved (hit or missed) this game.
REQ-016 react_time  output  16  ticks from target appearance to the most recent hit.
REQ-017 busy  output  1  high in ACTIVE or GAP.
REQ-018 done  output  1  high in DONE.

Function
REQ-019 SHALL implement states IDLE, ACTIVE, GAP, DONE; all outputs registered.
REQ-020 IDLE/DONE with start=1 and abort=0 -> ACTIVE next edge: jump_start=1 for exactly that one cycle; ball_visible=1; score, misses, round_num, react_time and timer cleared.
REQ-021 ACTIVE: each tick SHALL increment the 16-bit timer; cycles without tick leave it unchanged.
REQ-022 ACTIVE with hit=1: score+1, react_time<=timer, round_num+1, ball_visible<=0; next state GAP, or DONE if the new round_num==ROUNDS.
REQ-023 ACTIVE with tick=1, timer==TIMEOUT-1, hit=0: misses+1, round_num+1, ball_visible<=0, react_time unchanged; next state as in REQ-022.
REQ-024 hit and timeout in the same cycle SHALL count as a hit only.
REQ-025 GAP: gap counter increments on tick; on the tick where it reaches GAP_TICKS-1 -> ACTIVE with new_ball=1 for one cycle, ball_visible=1, timer=0, gap counter=0.
REQ-026 hit outside ACTIVE SHALL be ignored; start in ACTIVE/GAP SHALL be ignored.
REQ-027 abort=1 in any state SHALL force IDLE next edge with ball_visible=0 and no pulse; counters retain their values; abort has priority over start, hit and timeout.
REQ-028 DONE SHALL hold score/misses/round_num/react_time stable until start or abort.
REQ-029 jump_start and new_ball SHALL never be asserted together, and neither SHALL be asserted for more than one consecutive cycle.
REQ-030 score+misses SHALL equal round_num at all times; no counter wraps, given the legal ROUNDS range.

Reset
REQ-031 rst=1 SHALL force IDLE on the next edge: all outputs 0, timer and gap counter 0; rst has priority over every input.
REQ-032 rst mid-ACTIVE/GAP SHALL produce no new_ball or jump_start pulse in the reset cycle or the cycle after.

Verification
REQ-033 ROUNDS=3, TIMEOUT=5, GAP_TICKS=2, tick=1 every cycle; start pulse -> jump_start one cycle after start, ball_visible=1, busy=1.
REQ-034 Same setup; hit 3 cycles after jump_start -> score=1, react_time=3, round_num=1, ball_visible=0; new_ball 2 cycles later.
REQ-035 No hits -> each target is missed after 5 ticks; after the 3rd miss, done=1, misses=3, score=0, round_num=3.
REQ-036 hit on the same cycle as the 5th tick -> score increments, misses unchanged.
REQ-037 abort during GAP -> IDLE next edge, no new_ball; a later start -> jump_start and counters cleared.
REQ-038 rst asserted mid-ACTIVE with score=2 -> next edge all outputs 0, state IDLE; tick pulses gated to every 4th cycle -> timer advances only on tick cycles.
